// File: rtl/wb_fair_arbiter.sv
// -----------------------------------------------------------------------------
// wb_fair_arbiter
//   Two-master Wishbone arbiter with a starvation guard for the fetch side
//   and a stalled-strobe watchdog.
//   m0 is the data-side master and m1 is the fetch-side master. The arbiter
//   prefers m0, but m1 wins once m0 has taken STARVE_MAX grants in a row
//   while m1 was requesting.
//
// Handshake:
//   A grant covers a whole Wishbone cycle. The owner keeps the bus for as
//   long as its cyc stays high, and it is never preempted. Ownership is
//   decided again on any edge where there is no owner or the owner's cyc is
//   low, so a waiting master takes the bus on the very next cycle.
//   The slave-side signals are a combinational copy of the owner's signals.
//   Slave responses (ack/err/rty) go only to the owner.
//
// Ports:
//   i_clk, i_rst            clock and asynchronous active-low reset
//   mN_cyc/stb/we/adr/o_dat/sel   master N request (N = 0, 1)
//   mN_ack/err/rty          responses routed to master N
//   wb_cyc/stb/we/adr/o_dat/sel   shared slave bus
//   wb_ack/err/rty          slave responses
//   o_owner                 registered owner state: 00 none, 01 m0, 10 m1
//   o_timeout_cnt           saturating count of watchdog timeouts
// -----------------------------------------------------------------------------
module wb_fair_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int SEL_W      = 2,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_o_dat,
    input  logic [SEL_W-1:0]  m0_sel,
    output logic              m0_ack,
    output logic              m0_err,
    output logic              m0_rty,
    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_o_dat,
    input  logic [SEL_W-1:0]  m1_sel,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              m1_rty,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_adr,
    output logic [DATA_W-1:0] wb_o_dat,
    output logic [SEL_W-1:0]  wb_sel,
    input  logic              wb_ack,
    input  logic              wb_err,
    input  logic              wb_rty,
    output logic [1:0]        o_owner,
    output logic [7:0]        o_timeout_cnt
);

    // The starvation counter must be at least 3 bits wide, and wide enough
    // to hold STARVE_MAX.
    localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_SAT = '1;
    localparam logic [7:0]    TO_LIM     = 8'(TIMEOUT);
    localparam bit            TO_EN      = (TIMEOUT != 0);

    // The state encoding is the o_owner encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [7:0]      to_cnt_q, to_cnt_d;
    logic [7:0]      to_events_q, to_events_d;

    logic              own_cyc, own_stb, own_we;
    logic [ADDR_W-1:0] own_adr;
    logic [DATA_W-1:0] own_dat;
    logic [SEL_W-1:0]  own_sel;
    logic              decide, resp, at_limit, to_fire;

    // Select the owner's request signals. All of them are 0 when there is no owner.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        case (state_q)
            ST_OWN0: begin
                own_cyc = m0_cyc;
                own_stb = m0_stb;
                own_we  = m0_we;
                own_adr = m0_adr;
                own_dat = m0_o_dat;
                own_sel = m0_sel;
            end
            ST_OWN1: begin
                own_cyc = m1_cyc;
                own_stb = m1_stb;
                own_we  = m1_we;
                own_adr = m1_adr;
                own_dat = m1_o_dat;
                own_sel = m1_sel;
            end
            default: ;
        endcase
    end

    // Arbitration, starvation tracking and the watchdog.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        to_events_d = to_events_q;

        decide = (state_q == ST_IDLE) || !own_cyc;
        if (decide) begin
            if (m1_cyc && (starve_q >= STARVE_LIM || !m0_cyc)) begin
                state_d  = ST_OWN1;
                starve_d = '0;
            end else if (m0_cyc) begin
                state_d = ST_OWN0;
                if (m1_cyc && starve_q != STARVE_SAT) begin
                    starve_d = starve_q + 1'b1;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end

        resp     = wb_ack | wb_err | wb_rty;
        // At the limit the strobe is held off the bus. A slave response in
        // that same cycle takes priority over the timeout error.
        at_limit = TO_EN && (to_cnt_q == TO_LIM);
        to_fire  = at_limit && own_stb && !resp;

        if (state_d != state_q || !own_stb || resp || at_limit || !TO_EN) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 8'd1;
        end

        if (to_fire && to_events_q != 8'hFF) begin
            to_events_d = to_events_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            to_cnt_q    <= '0;
            to_events_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            to_cnt_q    <= to_cnt_d;
            to_events_q <= to_events_d;
        end
    end

    assign wb_cyc   = own_cyc;
    assign wb_stb   = own_stb && !at_limit;
    assign wb_we    = own_we;
    assign wb_adr   = own_adr;
    assign wb_o_dat = own_dat;
    assign wb_sel   = own_sel;

    assign m0_ack = (state_q == ST_OWN0) && wb_ack;
    assign m0_err = (state_q == ST_OWN0) && (wb_err || to_fire);
    assign m0_rty = (state_q == ST_OWN0) && wb_rty;
    assign m1_ack = (state_q == ST_OWN1) && wb_ack;
    assign m1_err = (state_q == ST_OWN1) && (wb_err || to_fire);
    assign m1_rty = (state_q == ST_OWN1) && wb_rty;

    assign o_owner       = state_q;
    assign o_timeout_cnt = to_events_q;

endmodule

// File: tb/tb_wb_fair_arbiter.sv
// Directed bench for wb_fair_arbiter. A second instance built with TIMEOUT=0
// shares the same stimulus, so the disabled watchdog can be checked in the
// same run.
module tb_wb_fair_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int SW = 2;

    logic          i_clk, i_rst;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [DW-1:0] m0_o_dat, m1_o_dat;
    logic [SW-1:0] m0_sel, m1_sel;
    logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_o_dat;
    logic [SW-1:0] wb_sel;
    logic          wb_ack, wb_err, wb_rty;
    logic [1:0]    o_owner;
    logic [7:0]    o_timeout_cnt;

    // Outputs of the TIMEOUT=0 instance.
    logic          n_m0_ack, n_m0_err, n_m0_rty, n_m1_ack, n_m1_err, n_m1_rty;
    logic          n_wb_cyc, n_wb_stb, n_wb_we;
    logic [AW-1:0] n_wb_adr;
    logic [DW-1:0] n_wb_o_dat;
    logic [SW-1:0] n_wb_sel;
    logic [1:0]    n_owner;
    logic [7:0]    n_to_cnt;

    int errors = 0;
    int checks = 0;

    wb_fair_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .STARVE_MAX(4), .TIMEOUT(255)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_o_dat(m0_o_dat), .m0_sel(m0_sel),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_o_dat(m1_o_dat), .m1_sel(m1_sel),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_o_dat(wb_o_dat), .wb_sel(wb_sel),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty),
        .o_owner(o_owner), .o_timeout_cnt(o_timeout_cnt)
    );

    wb_fair_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .STARVE_MAX(4), .TIMEOUT(0)) dut_nt (
        .i_clk(i_clk), .i_rst(i_rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_o_dat(m0_o_dat), .m0_sel(m0_sel),
        .m0_ack(n_m0_ack), .m0_err(n_m0_err), .m0_rty(n_m0_rty),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_o_dat(m1_o_dat), .m1_sel(m1_sel),
        .m1_ack(n_m1_ack), .m1_err(n_m1_err), .m1_rty(n_m1_rty),
        .wb_cyc(n_wb_cyc), .wb_stb(n_wb_stb), .wb_we(n_wb_we), .wb_adr(n_wb_adr),
        .wb_o_dat(n_wb_o_dat), .wb_sel(n_wb_sel),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty),
        .o_owner(n_owner), .o_timeout_cnt(n_to_cnt)
    );

    // Clock and reset.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Driver helpers.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst = 1'b0;
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
        m0_adr = '0; m1_adr = '0; m0_o_dat = '0; m1_o_dat = '0;
        m0_sel = '0; m1_sel = '0;
        {wb_ack, wb_err, wb_rty} = '0;

        // Reset state.
        step();
        settle();
        chk("rst_owner", 32'(o_owner), 32'd0);
        chk("rst_wb_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_to_cnt", 32'(o_timeout_cnt), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        i_rst = 1'b1;
        step();

        // Both masters raise cyc in the same cycle. m0 has priority.
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 24'h0A0A0A; m0_o_dat = 16'h1111; m0_sel = 2'b01;
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 24'h1B1B1B; m1_o_dat = 16'h2222; m1_sel = 2'b10;
        settle();
        chk("c0_owner", 32'(o_owner), 32'd0);
        chk("c0_wb_stb", 32'(wb_stb), 32'd0);
        step();
        chk("c1_owner", 32'(o_owner), 32'd1);
        chk("c1_wb_adr", 32'(wb_adr), 32'h0A0A0A);
        chk("c1_wb_dat", 32'(wb_o_dat), 32'h1111);
        chk("c1_wb_we", 32'(wb_we), 32'd1);
        chk("c1_wb_sel", 32'(wb_sel), 32'd1);
        chk("c1_wb_stb", 32'(wb_stb), 32'd1);

        // m0 lowers its strobe. m1 still has its strobe high, but m1 is not the owner.
        m0_stb = 0;
        settle();
        chk("nonowner_stb", 32'(wb_stb), 32'd0);
        wb_ack = 1;
        settle();
        chk("own0_m0_ack", 32'(m0_ack), 32'd1);
        chk("own0_m1_ack", 32'(m1_ack), 32'd0);
        step();
        wb_ack = 0;

        // m0 drops cyc. m1 owns the bus on the next cycle with no idle cycle.
        m0_cyc = 0;
        settle();
        chk("drop_owner_reg", 32'(o_owner), 32'd1);
        chk("drop_wb_cyc", 32'(wb_cyc), 32'd0);
        step();
        chk("hand_owner", 32'(o_owner), 32'd2);
        chk("hand_wb_adr", 32'(wb_adr), 32'h1B1B1B);
        chk("hand_wb_dat", 32'(wb_o_dat), 32'h2222);
        chk("hand_wb_we", 32'(wb_we), 32'd0);
        chk("hand_wb_cyc", 32'(wb_cyc), 32'd1);
        wb_ack = 1;
        settle();
        chk("own1_m1_ack", 32'(m1_ack), 32'd1);
        chk("own1_m0_ack", 32'(m0_ack), 32'd0);
        wb_ack = 0;

        // Watchdog: m1 raises its strobe and the slave never responds.
        m1_stb = 0;
        step();
        m1_stb = 1;
        repeat (254) step();
        chk("to_254_err", 32'(m1_err), 32'd0);
        step();
        chk("to_fire_m1_err", 32'(m1_err), 32'd1);
        chk("to_fire_m0_err", 32'(m0_err), 32'd0);
        chk("to_fire_wb_stb", 32'(wb_stb), 32'd0);
        chk("to_fire_cnt_pre", 32'(o_timeout_cnt), 32'd0);
        chk("nt_no_err", 32'(n_m1_err), 32'd0);
        step();
        chk("to_after_err", 32'(m1_err), 32'd0);
        chk("to_after_cnt", 32'(o_timeout_cnt), 32'd1);
        chk("to_after_stb", 32'(wb_stb), 32'd1);
        chk("nt_cnt", 32'(n_to_cnt), 32'd0);

        // The slave acks on the exact cycle the watchdog limit is reached.
        repeat (255) step();
        wb_ack = 1;
        settle();
        chk("race_m1_ack", 32'(m1_ack), 32'd1);
        chk("race_m1_err", 32'(m1_err), 32'd0);
        step();
        wb_ack = 0;
        m1_stb = 0;
        settle();
        chk("race_cnt", 32'(o_timeout_cnt), 32'd1);

        // Starvation guard: both masters request again from IDLE. m0 gets the
        // first four grants and m1 gets the fifth.
        m1_cyc = 0;
        step();
        chk("starve_idle", 32'(o_owner), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            m0_cyc = 1; m1_cyc = 1;
            step();
            chk($sformatf("starve_m0_grant%0d", k), 32'(o_owner), 32'd1);
            m0_cyc = 0; m1_cyc = 0;
            step();
        end
        m0_cyc = 1; m1_cyc = 1; m1_stb = 1;
        step();
        chk("starve_m1_grant", 32'(o_owner), 32'd2);
        chk("starve_wb_adr", 32'(wb_adr), 32'h1B1B1B);

        // Reset asserted in the middle of an m1 transfer.
        #2;
        i_rst = 0;
        settle();
        chk("midrst_wb_cyc", 32'(wb_cyc), 32'd0);
        chk("midrst_wb_stb", 32'(wb_stb), 32'd0);
        chk("midrst_owner", 32'(o_owner), 32'd0);
        chk("midrst_to_cnt", 32'(o_timeout_cnt), 32'd0);
        step();
        i_rst = 1;
        step();
        chk("postrst_owner", 32'(o_owner), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
